// File: rtl/mem_port_arbiter.sv
// Arbiter for port 2 of the external dual-port memory: display fetch (A) has priority,
// game/DMA engine (B) gets starvation protection and a bounded exclusive lock.
//
// state  | meaning
// ARB    | normal arbitration, A wins contested cycles unless B has waited MAX_WAIT
// LOCKED | B owns the port exclusively for an atomic sequence, bounded by MAX_LOCK
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 4,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic                  lock_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  lock_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [LW-1:0]   lock_cnt;
  logic            relock_block;
  logic            rvalid_a_q;
  logic            rvalid_b_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (state == LOCKED) begin
        gnt_b = req_b;
      end else if (req_a && req_b) begin
        if (wait_cnt == WAIT_MAX) gnt_b = 1'b1;
        else                      gnt_a = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    mem_addr = gnt_b ? addr_b  : addr_a;
    mem_din  = gnt_b ? wdata_b : wdata_a;
    mem_we   = (gnt_a & we_a) | (gnt_b & we_b);
  end

  // Masking with reset keeps a read that was in flight when reset hit from ever pulsing.
  assign rvalid_a = rvalid_a_q & ~reset;
  assign rvalid_b = rvalid_b_q & ~reset;
  assign rdata_a  = mem_dout;
  assign rdata_b  = mem_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB;
      wait_cnt     <= '0;
      lock_cnt     <= '0;
      lock_err     <= 1'b0;
      relock_block <= 1'b0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
    end else begin
      rvalid_a_q <= gnt_a & ~we_a;
      rvalid_b_q <= gnt_b & ~we_b;

      if (req_b && !gnt_b)
        wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
      else
        wait_cnt <= '0;

      if (!lock_b) relock_block <= 1'b0;

      case (state)
        ARB: begin
          if (gnt_b && lock_b && !relock_block) begin
            state    <= LOCKED;
            lock_cnt <= LW'(1);
          end
        end
        LOCKED: begin
          if (!lock_b) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_MAX) begin
            // B must release lock_b once before it may lock again.
            state        <= ARB;
            lock_cnt     <= '0;
            lock_err     <= 1'b1;
            relock_block <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read memory model on port 2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b, lock_b;
  logic [15:0] addr_a, wdata_a, addr_b, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, lock_err, mem_we;
  logic [15:0] rdata_a, rdata_b, mem_addr, mem_din, mem_dout;
  logic [15:0] mem [0:65535];
  logic [15:0] rd_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_WAIT(4), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .lock_b(lock_b), .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .lock_err(lock_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h1111;
    mem[16'h0021] = 16'h2222;
    mem[16'h0022] = 16'h3333;
    mem[16'h0040] = 16'h0005;
    mem_dout = 16'h0000;

    reset = 1'b1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0010; wdata_a = 16'hDEAD;
    req_b = 1'b1; we_b = 1'b1; addr_b = 16'h0011; wdata_b = 16'hCAFE; lock_b = 1'b0;
    #1;
    chk("reset_gnt_a", gnt_a, 0);
    chk("reset_gnt_b", gnt_b, 0);
    chk("reset_mem_we", mem_we, 0);
    cyc; cyc;
    chk("reset_rvalid_a", rvalid_a, 0);
    chk("reset_rvalid_b", rvalid_b, 0);
    chk("reset_lock_err", lock_err, 0);

    // A-only read
    reset = 1'b0; req_b = 1'b0; we_b = 1'b0; we_a = 1'b0; #1;
    chk("aread_gnt_a", gnt_a, 1);
    chk("aread_gnt_b", gnt_b, 0);
    chk("aread_mem_addr", mem_addr, 16'h0010);
    chk("aread_mem_we", mem_we, 0);
    cyc;
    req_a = 1'b0;
    chk("aread_rvalid_a", rvalid_a, 1);
    chk("aread_rdata_a", rdata_a, 16'hBEEF);
    chk("aread_rvalid_b", rvalid_b, 0);

    // Both request continuously: B force-granted after 4 denials, then again 5 later
    req_a = 1'b1; req_b = 1'b1; addr_b = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("starve_gnt_a_%0d", k), gnt_a, (k == 4 || k == 9) ? 0 : 1);
      chk($sformatf("starve_gnt_b_%0d", k), gnt_b, (k == 4 || k == 9) ? 1 : 0);
      cyc;
    end

    // Idle: nothing granted, address follows A
    req_a = 1'b0; req_b = 1'b0; addr_a = 16'h0033; #1;
    chk("idle_gnt_a", gnt_a, 0);
    chk("idle_gnt_b", gnt_b, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 16'h0033);
    cyc;

    // Alternating reads A/B/A with no bubbles
    req_a = 1'b1; addr_a = 16'h0020; cyc;
    chk("alt0_rvalid_a", rvalid_a, 1);
    chk("alt0_rdata_a", rdata_a, 16'h1111);
    chk("alt0_rvalid_b", rvalid_b, 0);
    req_a = 1'b0; req_b = 1'b1; addr_b = 16'h0021; cyc;
    chk("alt1_rvalid_b", rvalid_b, 1);
    chk("alt1_rdata_b", rdata_b, 16'h2222);
    chk("alt1_rvalid_a", rvalid_a, 0);
    req_a = 1'b1; req_b = 1'b0; addr_a = 16'h0022; cyc;
    chk("alt2_rvalid_a", rvalid_a, 1);
    chk("alt2_rdata_a", rdata_a, 16'h3333);
    chk("alt2_rvalid_b", rvalid_b, 0);

    // Locked read-modify-write; B enters the lock via starvation force-grant
    addr_a = 16'h0010; req_b = 1'b1; lock_b = 1'b1; we_b = 1'b0; addr_b = 16'h0040;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("lk_enter_gnt_b_%0d", k), gnt_b, (k == 4) ? 1 : 0);
      cyc;
    end
    chk("lk_rvalid_b", rvalid_b, 1);
    chk("lk_rdata_b", rdata_b, 16'h0005);
    rd_val = rdata_b;
    we_b = 1'b1; wdata_b = rd_val + 16'h0001; #1;
    chk("lk_wr_gnt_a", gnt_a, 0);
    chk("lk_wr_gnt_b", gnt_b, 1);
    chk("lk_wr_mem_we", mem_we, 1);
    chk("lk_wr_mem_din", mem_din, 16'h0006);
    cyc;
    chk("lk_wr_rvalid_b", rvalid_b, 0);
    req_b = 1'b0; we_b = 1'b0; lock_b = 1'b0; #1;
    chk("lk_release_gnt_a", gnt_a, 0);
    cyc;
    chk("lk_after_gnt_a", gnt_a, 1);
    chk("lk_mem_0x40", mem[16'h0040], 16'h0006);
    chk("lk_lock_err", lock_err, 0);
    cyc;

    // Lock timeout: B holds lock_b for too long
    req_a = 1'b0; req_b = 1'b1; lock_b = 1'b1; addr_b = 16'h0040; #1;
    chk("to_enter_gnt_b", gnt_b, 1);
    cyc;
    req_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("to_locked_gnt_a_%0d", k), gnt_a, 0);
      cyc;
    end
    chk("to_lock_err", lock_err, 1);
    // Back in ARB: A wins, B force-granted after 4, but no re-lock
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("to_arb_gnt_a_%0d", k), gnt_a, (k == 4) ? 0 : 1);
      cyc;
    end
    chk("to_lock_err_sticky", lock_err, 1);
    req_a = 1'b0; req_b = 1'b0; lock_b = 1'b0; cyc;
    req_b = 1'b1; lock_b = 1'b1; cyc;
    req_a = 1'b1; #1;
    chk("relock_gnt_a", gnt_a, 0);
    chk("relock_gnt_b", gnt_b, 1);
    lock_b = 1'b0; cyc;
    req_b = 1'b0; cyc;

    // Reset in the cycle after a granted read, with a write request pending
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0010; #1;
    chk("rst_pre_gnt_a", gnt_a, 1);
    cyc;
    reset = 1'b1; we_a = 1'b1; #1;
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_mem_we", mem_we, 0);
    cyc;
    chk("rst_after_rvalid_a", rvalid_a, 0);
    reset = 1'b0; req_a = 1'b0; we_a = 1'b0; #1;
    chk("rst_lock_err", lock_err, 0);
    chk("rst_rvalid_a2", rvalid_a, 0);
    cyc;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
